// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: channel state encoding, default sizes
// and the load-address width helper.
package timer_pkg;

  localparam int DEFAULT_N_CH  = 4;
  localparam int DEFAULT_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Channel-select width; a single-channel bank still gets a 1-bit address.
  function automatic int ch_sel_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Control/status bundle of the timer bank; master drives the requests and
// the terminal-value write port, slave (the bank) drives counts and flags.
interface timer_bank_if
  import timer_pkg::*;
#(
  parameter int N_CH  = DEFAULT_N_CH,
  parameter int WIDTH = DEFAULT_WIDTH
);

  localparam int LCH_W = ch_sel_width(N_CH);

  logic [N_CH-1:0]       i_Start;
  logic [N_CH-1:0]       i_Stop;
  logic [N_CH-1:0]       i_Clear;
  logic [N_CH-1:0]       i_Periodic;
  logic                  i_Load;
  logic [LCH_W-1:0]      i_LoadCh;
  logic [WIDTH-1:0]      i_LoadVal;
  logic [N_CH*WIDTH-1:0] o_Count;
  logic [N_CH-1:0]       o_Busy;
  logic [N_CH-1:0]       o_Done;
  logic [N_CH-1:0]       o_Expired;
  logic                  o_AnyDone;

  modport master (
    output i_Start, i_Stop, i_Clear, i_Periodic, i_Load, i_LoadCh, i_LoadVal,
    input  o_Count, o_Busy, o_Done, o_Expired, o_AnyDone
  );

  modport slave (
    input  i_Start, i_Stop, i_Clear, i_Periodic, i_Load, i_LoadCh, i_LoadVal,
    output o_Count, o_Busy, o_Done, o_Expired, o_AnyDone
  );

endinterface

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/HOLD/EXPIRED state machine, up-counter,
// programmable terminal and registered done pulse.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             periodic,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] term_reg;
  logic             done_reg, done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      term_reg  <= '1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      done_reg  <= done_next;
      if (load) begin
        term_reg <= load_val;
      end
    end
  end

  // Priority: clear, then stop, then start, then the count step.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    if (clear) begin
      state_next = IDLE;
      count_next = '0;
    end else if (stop) begin
      if (state_reg == RUN) begin
        state_next = HOLD;
      end
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) state_next = RUN;
        end
        HOLD: begin
          if (start) state_next = RUN;
        end
        EXPIRED: begin
          if (start) begin
            state_next = RUN;
            count_next = '0;
          end
        end
        RUN: begin
          // >= so a terminal lowered below the current count still fires.
          if (count_reg >= term_reg) begin
            done_next = 1'b1;
            if (periodic) begin
              count_next = '0;
            end else begin
              state_next = EXPIRED;
            end
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign count   = count_reg;
  assign busy    = (state_reg == RUN);
  assign expired = (state_reg == EXPIRED);
  assign done    = done_reg;

endmodule

// File: rtl/timer_bank.sv
// Bank of N_CH independent timer channels sharing one terminal-value write
// port; the write address is decoded here into per-channel load strobes.
module timer_bank
  import timer_pkg::*;
#(
  parameter int N_CH  = DEFAULT_N_CH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk_2K,
  input  logic         i_Reset,
  timer_bank_if.slave  bus
);

  logic [N_CH-1:0]       load_en;
  logic [N_CH*WIDTH-1:0] count_all;
  logic [N_CH-1:0]       busy_all;
  logic [N_CH-1:0]       done_all;
  logic [N_CH-1:0]       expired_all;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      // Addresses at or beyond N_CH match no channel and are dropped.
      assign load_en[gi] = bus.i_Load && (int'(bus.i_LoadCh) == gi);

      timer_channel #(
        .WIDTH (WIDTH)
      ) u_channel (
        .clk      (clk_2K),
        .rst_n    (i_Reset),
        .start    (bus.i_Start[gi]),
        .stop     (bus.i_Stop[gi]),
        .clear    (bus.i_Clear[gi]),
        .periodic (bus.i_Periodic[gi]),
        .load     (load_en[gi]),
        .load_val (bus.i_LoadVal),
        .count    (count_all[gi*WIDTH +: WIDTH]),
        .busy     (busy_all[gi]),
        .done     (done_all[gi]),
        .expired  (expired_all[gi])
      );
    end
  endgenerate

  assign bus.o_Count   = count_all;
  assign bus.o_Busy    = busy_all;
  assign bus.o_Done    = done_all;
  assign bus.o_Expired = expired_all;
  assign bus.o_AnyDone = |done_all;

endmodule

// File: tb/tb_timer_bank.sv
// Directed, self-checking bench for timer_bank: one task per scenario,
// hand-computed expected counts and flags.
`timescale 1ns/1ps
module tb_timer_bank;

  localparam int N = 4;
  localparam int W = 12;

  logic clk_2K  = 1'b0;
  logic i_Reset = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  timer_bank_if #(.N_CH(N), .WIDTH(W)) bus ();

  timer_bank #(.N_CH(N), .WIDTH(W)) dut (
    .clk_2K  (clk_2K),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  always #5 clk_2K = ~clk_2K;

  function automatic int cnt(input int k);
    return int'(bus.o_Count[k*W +: W]);
  endfunction

  task automatic tick();
    @(posedge clk_2K);
    #1;
  endtask

  task automatic load(input int ch, input int val);
    bus.i_Load    = 1'b1;
    bus.i_LoadCh  = ch[1:0];
    bus.i_LoadVal = val[W-1:0];
    tick();
    bus.i_Load    = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_Start = '0; bus.i_Stop = '0; bus.i_Clear = '0; bus.i_Periodic = '0;
    bus.i_Load = 1'b0; bus.i_LoadCh = '0; bus.i_LoadVal = '0;
    i_Reset = 1'b0;
    repeat (2) tick();
    checks++; if (bus.o_Count !== '0) begin errors++; $display("FAIL reset_count got %h expected 0", bus.o_Count); end
    checks++; if (bus.o_Busy !== '0 || bus.o_Done !== '0 || bus.o_Expired !== '0 || bus.o_AnyDone !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b done=%b exp=%b any=%b expected all 0", bus.o_Busy, bus.o_Done, bus.o_Expired, bus.o_AnyDone); end
    bus.i_Start = '1;
    tick();
    checks++; if (bus.o_Busy !== '0 || bus.o_Count !== '0) begin errors++; $display("FAIL reset_start_ignored got busy=%b count=%h expected 0", bus.o_Busy, bus.o_Count); end
    bus.i_Start = '0;
    i_Reset = 1'b1;
    tick();
    checks++; if (bus.o_Busy !== '0 || bus.o_Count !== '0) begin errors++; $display("FAIL reset_release got busy=%b count=%h expected 0", bus.o_Busy, bus.o_Count); end
  endtask

  task automatic test_oneshot();
    load(0, 3);
    bus.i_Start[0] = 1'b1;
    tick();
    bus.i_Start[0] = 1'b0;
    checks++; if (cnt(0) !== 0 || bus.o_Busy[0] !== 1'b1) begin errors++; $display("FAIL oneshot_start got count=%0d busy=%b expected 0/1", cnt(0), bus.o_Busy[0]); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (cnt(0) !== i || bus.o_Done[0] !== 1'b0) begin errors++; $display("FAIL oneshot_count got count=%0d done=%b expected %0d/0", cnt(0), bus.o_Done[0], i); end
    end
    tick();
    checks++; if (bus.o_Done[0] !== 1'b1 || bus.o_AnyDone !== 1'b1) begin errors++; $display("FAIL oneshot_done got done=%b any=%b expected 1/1", bus.o_Done[0], bus.o_AnyDone); end
    checks++; if (bus.o_Expired[0] !== 1'b1 || cnt(0) !== 3 || bus.o_Busy[0] !== 1'b0) begin
      errors++; $display("FAIL oneshot_expired got exp=%b count=%0d busy=%b expected 1/3/0", bus.o_Expired[0], cnt(0), bus.o_Busy[0]); end
    tick();
    checks++; if (bus.o_Done[0] !== 1'b0 || bus.o_Expired[0] !== 1'b1 || cnt(0) !== 3) begin
      errors++; $display("FAIL oneshot_hold got done=%b exp=%b count=%0d expected 0/1/3", bus.o_Done[0], bus.o_Expired[0], cnt(0)); end
    bus.i_Clear[0] = 1'b1;
    tick();
    bus.i_Clear[0] = 1'b0;
    checks++; if (cnt(0) !== 0 || bus.o_Expired[0] !== 1'b0) begin errors++; $display("FAIL oneshot_clear got count=%0d exp=%b expected 0/0", cnt(0), bus.o_Expired[0]); end
  endtask

  task automatic test_periodic();
    int exp_cnt [7] = '{0, 1, 2, 0, 1, 2, 0};
    logic exp_done [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    load(1, 2);
    bus.i_Periodic[1] = 1'b1;
    bus.i_Start[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (cnt(1) !== exp_cnt[i] || bus.o_Done[1] !== exp_done[i] || bus.o_Busy[1] !== 1'b1) begin
        errors++; $display("FAIL periodic_step%0d got count=%0d done=%b busy=%b expected %0d/%b/1", i, cnt(1), bus.o_Done[1], bus.o_Busy[1], exp_cnt[i], exp_done[i]); end
    end
    bus.i_Start[1] = 1'b0;
    bus.i_Clear[1] = 1'b1;
    tick();
    bus.i_Clear[1] = 1'b0;
    bus.i_Periodic[1] = 1'b0;
    checks++; if (cnt(1) !== 0 || bus.o_Done[1] !== 1'b0 || bus.o_Busy[1] !== 1'b0) begin
      errors++; $display("FAIL periodic_clear got count=%0d done=%b busy=%b expected 0/0/0", cnt(1), bus.o_Done[1], bus.o_Busy[1]); end
  endtask

  task automatic test_hold_resume();
    bus.i_Start[2] = 1'b1;
    tick();
    bus.i_Start[2] = 1'b0;
    repeat (5) tick();
    checks++; if (cnt(2) !== 5 || bus.o_Busy[2] !== 1'b1) begin errors++; $display("FAIL hold_pre got count=%0d busy=%b expected 5/1", cnt(2), bus.o_Busy[2]); end
    bus.i_Stop[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (cnt(2) !== 5 || bus.o_Busy[2] !== 1'b0) begin errors++; $display("FAIL hold_cycle%0d got count=%0d busy=%b expected 5/0", i, cnt(2), bus.o_Busy[2]); end
    end
    bus.i_Stop[2] = 1'b0;
    bus.i_Start[2] = 1'b1;
    tick();
    bus.i_Start[2] = 1'b0;
    checks++; if (cnt(2) !== 5 || bus.o_Busy[2] !== 1'b1) begin errors++; $display("FAIL hold_resume got count=%0d busy=%b expected 5/1", cnt(2), bus.o_Busy[2]); end
    tick();
    checks++; if (cnt(2) !== 6) begin errors++; $display("FAIL hold_next got count=%0d expected 6", cnt(2)); end
    bus.i_Clear[2] = 1'b1;
    tick();
    bus.i_Clear[2] = 1'b0;
  endtask

  task automatic test_load_lower();
    bus.i_Start[3] = 1'b1;
    tick();
    bus.i_Start[3] = 1'b0;
    repeat (10) tick();
    checks++; if (cnt(3) !== 10) begin errors++; $display("FAIL lower_pre got count=%0d expected 10", cnt(3)); end
    bus.i_Stop[3] = 1'b1;
    tick();
    bus.i_Stop[3] = 1'b0;
    load(3, 4);
    checks++; if (cnt(3) !== 10 || bus.o_Busy[3] !== 1'b0 || bus.o_Done[3] !== 1'b0) begin
      errors++; $display("FAIL lower_load_inert got count=%0d busy=%b done=%b expected 10/0/0", cnt(3), bus.o_Busy[3], bus.o_Done[3]); end
    bus.i_Start[3] = 1'b1;
    tick();
    bus.i_Start[3] = 1'b0;
    tick();
    checks++; if (bus.o_Done[3] !== 1'b1 || bus.o_Expired[3] !== 1'b1 || cnt(3) !== 10) begin
      errors++; $display("FAIL lower_fire got done=%b exp=%b count=%0d expected 1/1/10", bus.o_Done[3], bus.o_Expired[3], cnt(3)); end
    bus.i_Start[3] = 1'b1;
    tick();
    bus.i_Start[3] = 1'b0;
    checks++; if (bus.o_Expired[3] !== 1'b0 || cnt(3) !== 0 || bus.o_Busy[3] !== 1'b1) begin
      errors++; $display("FAIL lower_restart got exp=%b count=%0d busy=%b expected 0/0/1", bus.o_Expired[3], cnt(3), bus.o_Busy[3]); end
    bus.i_Clear[3] = 1'b1;
    tick();
    bus.i_Clear[3] = 1'b0;
  endtask

  task automatic test_start_stop_clear();
    bus.i_Start[0] = 1'b1;
    bus.i_Stop[0]  = 1'b1;
    bus.i_Start[1] = 1'b1;
    tick();
    bus.i_Start[0] = 1'b0;
    bus.i_Stop[0]  = 1'b0;
    bus.i_Start[1] = 1'b0;
    checks++; if (bus.o_Busy[0] !== 1'b0 || cnt(0) !== 0) begin errors++; $display("FAIL startstop_idle got busy=%b count=%0d expected 0/0", bus.o_Busy[0], cnt(0)); end
    tick();
    checks++; if (cnt(1) !== 1 || bus.o_Busy[1] !== 1'b1) begin errors++; $display("FAIL clrstart_pre got count=%0d busy=%b expected 1/1", cnt(1), bus.o_Busy[1]); end
    bus.i_Clear[1] = 1'b1;
    bus.i_Start[1] = 1'b1;
    tick();
    bus.i_Clear[1] = 1'b0;
    bus.i_Start[1] = 1'b0;
    checks++; if (cnt(1) !== 0 || bus.o_Busy[1] !== 1'b0 || bus.o_Done[1] !== 1'b0) begin
      errors++; $display("FAIL clrstart got count=%0d busy=%b done=%b expected 0/0/0", cnt(1), bus.o_Busy[1], bus.o_Done[1]); end
    tick();
    checks++; if (cnt(1) !== 0 || bus.o_Busy[1] !== 1'b0 || bus.o_Busy[0] !== 1'b0) begin
      errors++; $display("FAIL clrstart_stay got count1=%0d busy=%b expected 0/00", cnt(1), bus.o_Busy[1:0]); end
  endtask

  task automatic test_reset_midcount();
    i_Reset = 1'b0;
    tick();
    i_Reset = 1'b1;
    tick();
    bus.i_Start = '1;
    tick();
    bus.i_Start = '0;
    repeat (2000) tick();
    for (int k = 0; k < N; k++) begin
      checks++; if (cnt(k) !== 2000) begin errors++; $display("FAIL mid_count ch%0d got %0d expected 2000", k, cnt(k)); end
    end
    i_Reset = 1'b0;
    bus.i_Start = '1;
    #1;
    checks++; if (bus.o_Count !== '0 || bus.o_Busy !== '0 || bus.o_Done !== '0 || bus.o_Expired !== '0 || bus.o_AnyDone !== 1'b0) begin
      errors++; $display("FAIL async_reset got count=%h busy=%b done=%b exp=%b expected all 0", bus.o_Count, bus.o_Busy, bus.o_Done, bus.o_Expired); end
    tick();
    bus.i_Start = '0;
    i_Reset = 1'b1;
    tick();
    bus.i_Start[0] = 1'b1;
    bus.i_Start[1] = 1'b1;
    bus.i_Start[3] = 1'b1;
    tick();
    bus.i_Start = '0;
    repeat (4095) tick();
    checks++; if (cnt(0) !== 4095 || cnt(1) !== 4095 || cnt(3) !== 4095 || bus.o_Done !== '0) begin
      errors++; $display("FAIL term_restore_pre got c0=%0d c1=%0d c3=%0d done=%b expected 4095 x3/0000", cnt(0), cnt(1), cnt(3), bus.o_Done); end
    tick();
    checks++; if (bus.o_Done !== 4'b1011 || bus.o_Expired !== 4'b1011) begin
      errors++; $display("FAIL term_restore_fire got done=%b exp=%b expected 1011/1011", bus.o_Done, bus.o_Expired); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_hold_resume();
    test_load_lower();
    test_start_stop_clear();
    test_reset_midcount();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
